fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 3, number of requesters; ADDR_W, default 15, frame-buffer address width; DATA_W, default 24, RGB pixel width; MEM_SIZE, default 19200, number of valid frame-buffer words.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed pixel data, same packing.
- ack  out  NUM_REQ  one-hot grant, combinational.
- clear_start  in  1  start a full-buffer fill.
- clear_color  in  DATA_W  fill colour, sampled on accepted clear_start.
- clear_busy  out  1  fill in progress.
- clear_done  out  1  one-cycle pulse at fill completion.
- fb_addr  out  ADDR_W  frame-buffer write address, registered.
- fb_data  out  DATA_W  frame-buffer write data, registered.
- fb_we  out  1  frame-buffer write strobe, registered.
- err_oob  out  1  one-cycle pulse when a dropped request had address >= MEM_SIZE.

Function
REQ-003 The FSM SHALL have exactly two states: SERVE and CLEAR; reset state is SERVE.
REQ-004 In SERVE with clear_start=0 and any req bit high, ack SHALL assert for exactly one requester in that same cycle.
REQ-005 That requester SHALL be chosen round-robin: the first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-006 After each grant, rr_ptr SHALL become (winner+1) mod NUM_REQ; with no grant it SHALL hold.
REQ-007 On the edge ending a grant cycle, fb_addr and fb_data SHALL load the winner's req_addr and req_data, and fb_we SHALL be 1 for the next cycle (latency 1 clock from ack to fb_we).
REQ-008 A requester SHALL hold req, req_addr and req_data stable until it sees ack; it may change them in the cycle after ack; req held high means back-to-back writes.
REQ-009 If the granted address is >= MEM_SIZE, the request SHALL still be acked, fb_we SHALL stay 0 next cycle, and err_oob SHALL pulse 1 in that next cycle.
REQ-010 In cycles with no grant and no fill write, fb_we SHALL be 0 and fb_addr/fb_data SHALL hold their last values.
REQ-011 clear_start=1 in SERVE SHALL enter CLEAR, latch clear_color, set the fill counter to 0 and assert no ack that cycle; clear_start beats any simultaneous req.
REQ-012 In CLEAR, each cycle SHALL register fb_addr=counter, fb_data=latched colour, fb_we=1, then increment the counter; ack SHALL be all-zero; req is ignored and left pending.
REQ-013 After the write at address MEM_SIZE-1, the FSM SHALL return to SERVE and clear_done SHALL pulse 1 in the cycle in which that last fb_we is high.
REQ-014 clear_busy SHALL be 1 for exactly every cycle in CLEAR, i.e. MEM_SIZE cycles per fill.
REQ-015 clear_start while in CLEAR SHALL be ignored; there is no restart or queueing.
REQ-016 The fill counter SHALL be ADDR_W bits wide, compared against MEM_SIZE-1 with no wrap, and SHALL never emit an address >= MEM_SIZE.

Reset
REQ-017 Asserting rst at any time, including mid-fill, SHALL asynchronously force state=SERVE, rr_ptr=0, counter=0, fb_we=0, fb_addr=0, fb_data=0, clear_busy=0, clear_done=0, err_oob=0; ack is then 0 until the first cycle after rst deasserts.
REQ-018 A fill aborted by reset SHALL NOT resume; no clear_done SHALL be produced for it.

Structure
REQ-019 MEM_SIZE, ADDR_W, DATA_W and the FSM state encoding SHALL live in the shared package fb_pkg, which the frame driver and game FSM also use.
REQ-020 The round-robin selection logic SHALL be one sub-module, rr_select (inputs req and rr_ptr; output one-hot grant), and everything else stays flat.

Verification
REQ-021 Scenario 1, single requester: req=3'b001, addr 235, data FFFFFF -> ack[0]=1 that cycle; next cycle fb_we=1, fb_addr=235, fb_data=FFFFFF.
REQ-022 Scenario 2, contention: req=3'b111 held for 6 cycles after reset -> ack order 0,1,2,0,1,2 with one fb_we per cycle.
REQ-023 Scenario 3, fill: clear_start with clear_color=000000 -> 19200 consecutive fb_we cycles at addresses 0..19199; clear_done pulses with address 19199; clear_busy is 1 for exactly 19200 cycles.
REQ-024 Scenario 4, clear priority: clear_start and req=3'b010 in the same cycle -> no ack during the fill; ack[1]=1 in the first SERVE cycle after the fill.
REQ-025 Scenario 5, out-of-bounds: req[2] with addr 19200 -> ack[2]=1; next cycle fb_we=0 and err_oob=1.
REQ-026 Scenario 6, reset mid-fill: rst pulse at counter 5000 -> all outputs go to reset values immediately; no clear_done follows; the next fill starts again at address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry and arbiter FSM encoding shared by the frame driver, game FSM and write arbiter.
package fb_pkg;
  localparam int MEM_SIZE = 19200;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 24;
  typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} fsm_state_t;
endpackage

// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: requester, clear-control and frame-buffer write signals of the write arbiter.
interface fb_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] ack;
  logic clear_start;
  logic [DATA_W-1:0] clear_color;
  logic clear_busy;
  logic clear_done;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic fb_we;
  logic err_oob;
  modport master (
    output req, req_addr, req_data, clear_start, clear_color,
    input ack, clear_busy, clear_done, fb_addr, fb_data, fb_we, err_oob
  );
  modport slave (
    input req, req_addr, req_data, clear_start, clear_color,
    output ack, clear_busy, clear_done, fb_addr, fb_data, fb_we, err_oob
  );
endinterface

// File: rtl/fb_write_arbiter_rr_select.sv
// rr_select: one-hot grant to the first requesting index at or after rr_ptr, wrapping.
module rr_select #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant
);
  always_comb begin
    grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) grant = NUM_REQ'(1) << idx;
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin frame-buffer write arbiter with a full-buffer colour fill mode.
module fb_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int MEM_SIZE = fb_pkg::MEM_SIZE
) (
  input logic clk,
  input logic rst,
  fb_write_arbiter_if.slave bus
);
  import fb_pkg::*;
  localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);
  fsm_state_t state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, win;
  logic [ADDR_W-1:0] cnt_q, cnt_d, fb_addr_q, fb_addr_d, addr_w;
  logic [DATA_W-1:0] color_q, color_d, fb_data_q, fb_data_d, data_w;
  logic fb_we_q, fb_we_d, done_q, done_d, oob_q, oob_d;
  logic [NUM_REQ-1:0] grant;
  logic serve, oob;
  rr_select #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_sel (
    .req(bus.req),
    .rr_ptr(rr_ptr_q),
    .grant(grant)
  );
  // no ack while reset is held, in CLEAR, or when a fill is being started
  assign serve = state_q == SERVE && !bus.clear_start && !rst;
  assign bus.ack = serve ? grant : '0;
  assign bus.clear_busy = state_q == CLEAR;
  assign bus.clear_done = done_q;
  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_data = fb_data_q;
  assign bus.fb_we = fb_we_q;
  assign bus.err_oob = oob_q;
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) win = PTR_W'(i);
    addr_w = bus.req_addr[win*ADDR_W +: ADDR_W];
    data_w = bus.req_data[win*DATA_W +: DATA_W];
    oob = addr_w > LAST;
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d = cnt_q;
    color_d = color_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    fb_we_d = 1'b0;
    done_d = 1'b0;
    oob_d = 1'b0;
    if (state_q == CLEAR) begin
      fb_addr_d = cnt_q;
      fb_data_d = color_q;
      fb_we_d = 1'b1;
      done_d = cnt_q == LAST;
      state_d = cnt_q == LAST ? SERVE : CLEAR;
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
    end else if (bus.clear_start) begin
      state_d = CLEAR;
      color_d = bus.clear_color;
      cnt_d = '0;
    end else if (|bus.ack) begin
      rr_ptr_d = int'(win) == NUM_REQ - 1 ? '0 : win + PTR_W'(1);
      fb_addr_d = addr_w;
      fb_data_d = data_w;
      fb_we_d = !oob;
      oob_d = oob;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SERVE;
      rr_ptr_q <= '0;
      cnt_q <= '0;
      color_q <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      fb_we_q <= 1'b0;
      done_q <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
      color_q <= color_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      fb_we_q <= fb_we_d;
      done_q <= done_d;
      oob_q <= oob_d;
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_fb_write_arbiter;
  localparam int N = 3;
  localparam int AW = 15;
  localparam int DW = 24;
  localparam int MS = 19200;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req_v = '0;
  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];
  logic cs = 1'b0;
  logic [DW-1:0] cc = '0;
  int vectors = 0, miscompares = 0;
  int rr = 0, cnt = 0, done_count = 0;
  bit filling = 0, m_we = 0, m_done = 0, m_oob = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0, color = '0;
  int obs_busy = 0, obs_we = 0, obs_done = 0;
  fb_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  fb_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_SIZE(MS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always_comb begin
    bus.req = req_v;
    bus.clear_start = cs;
    bus.clear_color = cc;
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = ra[i];
      bus.req_data[i*DW +: DW] = rd[i];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    rr = 0; cnt = 0; filling = 0;
    m_we = 0; m_done = 0; m_oob = 0; m_addr = '0; m_data = '0;
  endtask
  task automatic check_reset_outputs();
    check("rst_ack", bus.ack, 0);
    check("rst_we", bus.fb_we, 0);
    check("rst_addr", bus.fb_addr, 0);
    check("rst_data", bus.fb_data, 0);
    check("rst_busy", bus.clear_busy, 0);
    check("rst_done", bus.clear_done, 0);
    check("rst_oob", bus.err_oob, 0);
  endtask
  // one clock: compare DUT against the model mid-cycle, then advance the model at the edge
  task automatic step(output int win);
    logic [N-1:0] ea;
    @(negedge clk);
    win = -1;
    ea = '0;
    if (!rst && !filling && !cs)
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr + k) % N;
        if (win < 0 && req_v[idx]) win = idx;
      end
    if (win >= 0) ea[win] = 1'b1;
    check("ack", bus.ack, ea);
    check("fb_we", bus.fb_we, m_we);
    check("fb_addr", bus.fb_addr, m_addr);
    check("fb_data", bus.fb_data, m_data);
    check("clear_done", bus.clear_done, m_done);
    check("err_oob", bus.err_oob, m_oob);
    check("clear_busy", bus.clear_busy, filling);
    obs_busy += int'(bus.clear_busy);
    obs_we += int'(bus.fb_we);
    obs_done += int'(bus.clear_done);
    if (bus.clear_done) check("done_addr", bus.fb_addr, MS - 1);
    @(posedge clk);
    m_we = 0; m_done = 0; m_oob = 0;
    if (rst) model_reset();
    else if (filling) begin
      m_addr = AW'(cnt); m_data = color; m_we = 1;
      if (cnt == MS - 1) begin filling = 0; m_done = 1; done_count++; end
      cnt++;
    end else if (cs) begin
      filling = 1; cnt = 0; color = cc;
    end else if (win >= 0) begin
      m_addr = ra[win]; m_data = rd[win];
      if (int'(ra[win]) >= MS) m_oob = 1; else m_we = 1;
      rr = (win + 1) % N;
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int w;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; end
    #2;
    do_reset();
    // single requester
    req_v = 3'b001; ra[0] = 15'd235; rd[0] = 24'hFFFFFF;
    step(w);
    check("s1_win", w, 0);
    check("s1_we", bus.fb_we, 1);
    check("s1_addr", bus.fb_addr, 235);
    check("s1_data", bus.fb_data, 24'hFFFFFF);
    req_v = '0;
    step(w);
    // contention from a fresh reset
    do_reset();
    req_v = 3'b111;
    for (int i = 0; i < N; i++) begin ra[i] = AW'(100 + i); rd[i] = DW'(i + 7); end
    for (int k = 0; k < 6; k++) begin
      step(w);
      check("s2_order", w, k % 3);
      check("s2_we", bus.fb_we, 1);
    end
    req_v = '0;
    step(w);
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      step(w);
      for (int i = 0; i < N; i++)
        if (!req_v[i] || w == i) begin
          req_v[i] = $urandom_range(0, 2) != 0;
          ra[i] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(MS, 32767)) : AW'($urandom_range(0, MS - 1));
          rd[i] = DW'($urandom);
        end
    end
    req_v = '0;
    step(w);
    // out-of-bounds request
    req_v = 3'b100; ra[2] = 15'd19200; rd[2] = 24'h123456;
    step(w);
    check("s5_win", w, 2);
    check("s5_we", bus.fb_we, 0);
    check("s5_oob", bus.err_oob, 1);
    req_v = '0;
    step(w);
    check("s5_oob_pulse", bus.err_oob, 0);
    // full fill, with clear_start pokes that must be ignored
    obs_busy = 0; obs_we = 0; obs_done = 0;
    cs = 1'b1; cc = 24'h000000;
    step(w);
    check("s3_start_ack", w, -1);
    cs = 1'b0;
    for (int c = 0; c < MS + 2; c++) begin
      cs = filling && $urandom_range(0, 99) == 0;
      cc = DW'($urandom);
      step(w);
    end
    cs = 1'b0;
    check("s3_busy_cycles", obs_busy, MS);
    check("s3_we_cycles", obs_we, MS);
    check("s3_done_count", obs_done, 1);
    // clear beats a simultaneous request, which is served right after the fill
    req_v = 3'b010; ra[1] = 15'd77; rd[1] = 24'hABCDEF;
    cs = 1'b1; cc = 24'h00FF00;
    step(w);
    check("s4_start_ack", w, -1);
    cs = 1'b0;
    for (int c = 0; c < MS + 10 && filling; c++) begin
      step(w);
      if (w >= 0) check("s4_fill_ack", w, -1);
    end
    check("s4_fill_ended", filling, 0);
    step(w);
    check("s4_after_win", w, 1);
    req_v = '0;
    step(w);
    check("s4_after_addr", bus.fb_addr, 77);
    // reset in the middle of a fill
    cs = 1'b1; cc = 24'h0000FF;
    step(w);
    cs = 1'b0;
    for (int c = 0; c < MS && cnt != 5000; c++) step(w);
    check("s6_reached", cnt, 5000);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    step(w);
    rst = 1'b0;
    obs_done = 0;
    for (int c = 0; c < 20; c++) step(w);
    check("s6_no_done", obs_done, 0);
    cs = 1'b1; cc = 24'h112233;
    step(w);
    cs = 1'b0;
    step(w);
    check("s6_restart_we", bus.fb_we, 1);
    check("s6_restart_addr", bus.fb_addr, 0);
    check("s6_restart_data", bus.fb_data, 24'h112233);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
